// File: rtl/keypad_if.sv
// Key event bus between the keypad scanner and its consumers
// (stack calculator input logic, display controller).
//
// Signalling: there is no back-pressure. key_valid is a level that stays high
// for as long as a debounced single key is committed, and key_code is only
// meaningful while it is high. key_press and key_release are single-cycle
// strobes that a consumer must take on the cycle they are high. multi_key is
// a level that stays high while two or more keys are committed. fsm_state
// mirrors the commit FSM for observation.
interface keypad_if #(
  parameter int CODE_W = 4
);
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_press;
  logic              key_release;
  logic              multi_key;
  logic [1:0]        fsm_state;

  modport master (
    output key_code,
    output key_valid,
    output key_press,
    output key_release,
    output multi_key,
    output fsm_state
  );

  modport slave (
    input key_code,
    input key_valid,
    input key_press,
    input key_release,
    input multi_key,
    input fsm_state
  );
endinterface

// File: rtl/keypad_scanner.sv
// R x C matrix keypad scanner. Drives one column low at a time, samples the
// synchronised rows at the end of each column period, and builds a per-frame
// result (none / one key / several keys). A result is committed only after it
// has been seen in DEBOUNCE consecutive frames.
module keypad_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 100000,
  parameter int DEBOUNCE = 4,
  parameter int CODE_W   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [COLS-1:0] col_n,
  input  logic [ROWS-1:0] row_n,
  keypad_if.master        key_bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_t;
  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_MULTI} state_t;

  logic [ROWS-1:0]   row_s1, row_s2;
  logic [DIV_W-1:0]  div;
  logic [COL_W-1:0]  col_idx;
  logic [1:0]        acc_hits;
  logic [CODE_W-1:0] acc_code;
  res_t              cand_res;
  logic [CODE_W-1:0] cand_code;
  logic [3:0]        cnt;
  state_t            state, state_nx;
  logic [CODE_W-1:0] code_q, code_nx;
  logic              press_q, press_nx, release_q, release_nx;

  logic              sample, frame_end;
  logic [1:0]        col_hits;
  logic [ROW_W-1:0]  col_row;
  logic [CODE_W-1:0] col_code;
  logic [1:0]        base_hits, f_hits;
  logic [CODE_W-1:0] base_code, f_code;
  logic [2:0]        hit_sum;
  res_t              f_res;
  logic [CODE_W-1:0] f_res_code;
  res_t              com_res;
  logic [CODE_W-1:0] com_code;
  logic              do_commit;

  assign sample    = (div == DIV_W'(SCAN_DIV - 1));
  assign frame_end = sample && (col_idx == COL_W'(COLS - 1));
  assign col_n     = ~(COLS'(1) << col_idx);

  // Two-flop synchroniser on the row pins; idle level is all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= row_n;
      row_s2 <= row_s1;
    end
  end

  // Hits on the current column: count (saturating at 2) and lowest row hit.
  always_comb begin
    col_hits = 2'd0;
    col_row  = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!row_s2[r] && col_hits != 2'd2) col_hits = col_hits + 2'd1;
    end
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!row_s2[r]) col_row = ROW_W'(r);
    end
  end

  // Merge this column into the frame accumulator; column 0 starts a new frame.
  always_comb begin
    col_code   = CODE_W'(col_row) * CODE_W'(COLS) + CODE_W'(col_idx);
    base_hits  = (col_idx == '0) ? 2'd0 : acc_hits;
    base_code  = (col_idx == '0) ? '0 : acc_code;
    hit_sum    = {1'b0, base_hits} + {1'b0, col_hits};
    f_hits     = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    f_code     = (base_hits == 2'd0) ? col_code : base_code;
    f_res      = RES_NONE;
    f_res_code = '0;
    case (f_hits)
      2'd0:    f_res = RES_NONE;
      2'd1:    begin f_res = RES_KEY; f_res_code = f_code; end
      default: f_res = RES_MULTI;
    endcase
  end

  // Column divider, column index and per-frame hit accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div      <= '0;
      col_idx  <= '0;
      acc_hits <= 2'd0;
      acc_code <= '0;
    end else if (sample) begin
      div      <= '0;
      col_idx  <= (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + 1'b1;
      acc_hits <= f_hits;
      acc_code <= f_code;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Frame-level debounce: count consecutive identical frame results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_res  <= RES_NONE;
      cand_code <= '0;
      cnt       <= 4'd0;
    end else if (frame_end) begin
      if (f_res == cand_res && f_res_code == cand_code) begin
        cnt <= (cnt == 4'd15) ? 4'd15 : cnt + 4'd1;
      end else begin
        cand_res  <= f_res;
        cand_code <= f_res_code;
        cnt       <= 4'd1;
      end
    end
  end

  // Committed result as seen by the debounce comparison.
  always_comb begin
    com_res  = RES_NONE;
    com_code = '0;
    case (state)
      ST_HELD:  begin com_res = RES_KEY; com_code = code_q; end
      ST_MULTI: com_res = RES_MULTI;
      default:  com_res = RES_NONE;
    endcase
    do_commit = (cnt >= 4'(DEBOUNCE)) &&
                ((cand_res != com_res) || (cand_code != com_code));
  end

  // Commit FSM state register with code and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      code_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state     <= state_nx;
      code_q    <= code_nx;
      press_q   <= press_nx;
      release_q <= release_nx;
    end
  end

  // Commit FSM next state; strobes mark entry to and exit from HELD.
  always_comb begin
    state_nx   = state;
    code_nx    = code_q;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    if (do_commit) begin
      release_nx = (state == ST_HELD);
      case (cand_res)
        RES_KEY: begin
          state_nx = ST_HELD;
          code_nx  = cand_code;
          press_nx = 1'b1;
        end
        RES_MULTI: state_nx = ST_MULTI;
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  assign key_bus.key_code    = code_q;
  assign key_bus.key_valid   = (state == ST_HELD);
  assign key_bus.multi_key   = (state == ST_MULTI);
  assign key_bus.key_press   = press_q;
  assign key_bus.key_release = release_q;
  assign key_bus.fsm_state   = state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a 4x4 keypad model, SCAN_DIV=8,
// DEBOUNCE=3 (one frame = 32 cycles). Edge numbers in comments count rising
// edges after reset release.
module tb_keypad_scanner;
  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 8, DEBOUNCE = 3, CODE_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [COLS-1:0] col_n;
  logic [ROWS-1:0] row_n;
  logic [ROWS*COLS-1:0] keys = '0;
  int checks = 0, failures = 0;
  int press_cnt = 0, release_cnt = 0;

  keypad_if #(.CODE_W(CODE_W)) kbus ();

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE), .CODE_W(CODE_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .col_n(col_n),
    .row_n(row_n),
    .key_bus(kbus)
  );

  // Clock
  always #5 clk = ~clk;

  // Keypad model: a closed key pulls its row low while its column is driven.
  always_comb begin
    row_n = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (keys[r*COLS+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  // Strobe counters
  always @(negedge clk) begin
    if (kbus.key_press) press_cnt++;
    if (kbus.key_release) release_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Hold reset for 3 cycles with the given keys, release at a falling edge.
  task automatic do_reset(input logic [15:0] k);
    rst_n = 1'b0;
    keys  = k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    rst_n = 1'b0;
    keys  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({col_n, kbus.key_code, kbus.key_valid, kbus.key_press, kbus.key_release,
         kbus.multi_key, kbus.fsm_state} !== {4'b1110, 4'd0, 4'b0000, 2'd0}) begin
      failures++;
      $display("FAIL reset_state: col_n=%b code=%0d flags=%b%b%b%b state=%0d", col_n,
               kbus.key_code, kbus.key_valid, kbus.key_press, kbus.key_release,
               kbus.multi_key, kbus.fsm_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 320; n++) begin
      exp_col = ~(4'b0001 << ((n / 8) % 4));
      checks++;
      if ({col_n, kbus.key_valid, kbus.key_press, kbus.key_release, kbus.multi_key}
          !== {exp_col, 4'b0000}) begin
        failures++;
        $display("FAIL idle_scan edge %0d: col_n=%b flags=%b%b%b%b want col_n=%b flags=0000",
                 n, col_n, kbus.key_valid, kbus.key_press, kbus.key_release,
                 kbus.multi_key, exp_col);
      end
      step(1);
    end
  endtask

  task automatic test_press_release();
    int p0, r0;
    do_reset(16'h0200);                     // code 9 = row 2, col 1
    #1; p0 = press_cnt; r0 = release_cnt;
    @(negedge clk);
    step(95);                               // edge 96: last frame end, not yet committed
    checks++;
    if (kbus.key_valid !== 1'b0 || kbus.key_press !== 1'b0) begin
      failures++;
      $display("FAIL early_commit: valid=%b press=%b want 0 0", kbus.key_valid, kbus.key_press);
    end
    step(1);                                // edge 97: commit
    checks++;
    if ({kbus.key_press, kbus.key_valid, kbus.key_code} !== {1'b1, 1'b1, 4'd9}) begin
      failures++;
      $display("FAIL press_commit: press=%b valid=%b code=%0d want 1 1 9",
               kbus.key_press, kbus.key_valid, kbus.key_code);
    end
    step(1);
    keys = '0;
    checks++;
    if (kbus.key_press !== 1'b0) begin
      failures++;
      $display("FAIL press_width: press=%b want 0", kbus.key_press);
    end
    step(94);                               // edge 192: release not yet committed
    checks++;
    if (kbus.key_valid !== 1'b1 || kbus.key_release !== 1'b0) begin
      failures++;
      $display("FAIL early_release: valid=%b release=%b want 1 0",
               kbus.key_valid, kbus.key_release);
    end
    step(1);                                // edge 193
    checks++;
    if ({kbus.key_release, kbus.key_valid, kbus.key_code} !== {1'b1, 1'b0, 4'd9}) begin
      failures++;
      $display("FAIL release_commit: release=%b valid=%b code=%0d want 1 0 9",
               kbus.key_release, kbus.key_valid, kbus.key_code);
    end
    step(2);
    #1;
    checks++;
    if (press_cnt - p0 !== 1 || release_cnt - r0 !== 1) begin
      failures++;
      $display("FAIL strobe_counts: press=%0d release=%0d want 1 1",
               press_cnt - p0, release_cnt - r0);
    end
  endtask

  task automatic test_bounce();
    int p0, r0;
    do_reset(16'h0000);
    #1; p0 = press_cnt; r0 = release_cnt;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      keys = (k % 2 == 0) ? 16'h0200 : 16'h0000;
      step(32);
    end
    keys = '0;
    step(100);
    #1;
    checks++;
    if (press_cnt - p0 !== 0 || release_cnt - r0 !== 0 || kbus.key_valid !== 1'b0) begin
      failures++;
      $display("FAIL bounce: press=%0d release=%0d valid=%b want 0 0 0",
               press_cnt - p0, release_cnt - r0, kbus.key_valid);
    end
  endtask

  task automatic test_multi();
    int p0, r0;
    do_reset(16'h0021);                     // codes 0 and 5
    #1; p0 = press_cnt; r0 = release_cnt;
    @(negedge clk);
    step(96);                               // edge 97
    #1;
    checks++;
    if ({kbus.multi_key, kbus.key_valid} !== 2'b10 || press_cnt - p0 !== 0) begin
      failures++;
      $display("FAIL multi_commit: multi=%b valid=%b presses=%0d want 1 0 0",
               kbus.multi_key, kbus.key_valid, press_cnt - p0);
    end
    keys = 16'h0001;                        // drop code 5
    @(negedge clk);
    step(94);                               // edge 192
    checks++;
    if (kbus.multi_key !== 1'b1 || kbus.key_valid !== 1'b0) begin
      failures++;
      $display("FAIL multi_hold: multi=%b valid=%b want 1 0", kbus.multi_key, kbus.key_valid);
    end
    step(1);                                // edge 193
    #1;
    checks++;
    if ({kbus.key_valid, kbus.multi_key, kbus.key_code, kbus.key_press} !== {1'b1, 1'b0, 4'd0, 1'b1}
        || press_cnt - p0 !== 1 || release_cnt - r0 !== 0) begin
      failures++;
      $display("FAIL multi_to_held: valid=%b multi=%b code=%0d press=%b presses=%0d releases=%0d want 1 0 0 1 1 0",
               kbus.key_valid, kbus.multi_key, kbus.key_code, kbus.key_press,
               press_cnt - p0, release_cnt - r0);
    end
    keys = '0;
  endtask

  task automatic test_back_to_back();
    do_reset(16'h8000);                     // code 15
    step(97);                               // edge 97
    checks++;
    if ({kbus.key_valid, kbus.key_code, kbus.key_press} !== {1'b1, 4'd15, 1'b1}) begin
      failures++;
      $display("FAIL held_15: valid=%b code=%0d press=%b want 1 15 1",
               kbus.key_valid, kbus.key_code, kbus.key_press);
    end
    keys = 16'h0008;                        // code 3
    step(95);                               // edge 192
    checks++;
    if ({kbus.key_press, kbus.key_release, kbus.key_code} !== {2'b00, 4'd15}) begin
      failures++;
      $display("FAIL pre_switch: press=%b release=%b code=%0d want 0 0 15",
               kbus.key_press, kbus.key_release, kbus.key_code);
    end
    step(1);                                // edge 193
    checks++;
    if ({kbus.key_press, kbus.key_release, kbus.key_valid, kbus.key_code} !== {3'b111, 4'd3}) begin
      failures++;
      $display("FAIL switch_strobes: press=%b release=%b valid=%b code=%0d want 1 1 1 3",
               kbus.key_press, kbus.key_release, kbus.key_valid, kbus.key_code);
    end
    keys = '0;
  endtask

  task automatic test_mid_reset();
    int p0, r0;
    do_reset(16'h0080);                     // code 7 = row 1, col 3
    step(110);                              // mid frame 3, key committed
    checks++;
    if (kbus.key_valid !== 1'b1 || kbus.key_code !== 4'd7) begin
      failures++;
      $display("FAIL pre_reset_held: valid=%b code=%0d want 1 7", kbus.key_valid, kbus.key_code);
    end
    #1; p0 = press_cnt; r0 = release_cnt;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({col_n, kbus.key_code, kbus.key_valid, kbus.key_press, kbus.key_release, kbus.multi_key}
        !== {4'b1110, 4'd0, 4'b0000}) begin
      failures++;
      $display("FAIL async_reset: col_n=%b code=%0d flags=%b%b%b%b want 1110 0 0000",
               col_n, kbus.key_code, kbus.key_valid, kbus.key_press, kbus.key_release,
               kbus.multi_key);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(96);                               // edge 96
    checks++;
    if (kbus.key_valid !== 1'b0) begin
      failures++;
      $display("FAIL recommit_early: valid=%b want 0", kbus.key_valid);
    end
    step(1);                                // edge 97
    checks++;
    if ({kbus.key_press, kbus.key_valid, kbus.key_code} !== {2'b11, 4'd7}) begin
      failures++;
      $display("FAIL recommit: press=%b valid=%b code=%0d want 1 1 7",
               kbus.key_press, kbus.key_valid, kbus.key_code);
    end
    step(2);
    #1;
    checks++;
    if (press_cnt - p0 !== 1 || release_cnt - r0 !== 0) begin
      failures++;
      $display("FAIL reset_strobes: presses=%0d releases=%0d want 1 0",
               press_cnt - p0, release_cnt - r0);
    end
    keys = '0;
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_multi();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
